fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning fetch buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning ROM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rom_addr  output  ADDR_W  word address to the combinational instruction ROM.
REQ-007 SHALL have port rom_data  input  DATA_W  ROM word at rom_addr, same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  ADDR_W  redirect target word address.
REQ-010 SHALL have port out_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port out_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  DATA_W  head instruction.
REQ-013 SHALL have port out_pc  output  ADDR_W  head instruction word address.
REQ-014 SHALL have port fetch_done  output  1  controller is in DONE.
REQ-015 SHALL have port buf_count  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-016 SHALL drive rom_addr = pc register at all times.
REQ-017 SHALL implement states FETCH and DONE; reset enters FETCH.
REQ-018 In FETCH, SHALL push {pc, rom_data} when buf_count < DEPTH, or when the buffer is full and a pop occurs in the same cycle, then increment pc by 1.
REQ-019 SHALL treat rom_data == 0 as end-of-trace: do not push, keep pc, enter DONE next cycle.
REQ-020 SHALL push the word at pc == 2^ADDR_W-1 normally, then enter DONE instead of wrapping pc.
REQ-021 In DONE, SHALL not push; buffered entries SHALL still drain.
REQ-022 SHALL pop the head when out_valid && out_ready; out_valid = (buf_count != 0).
REQ-023 out_instr/out_pc SHALL come from buffer registers only (no combinational path from rom_data or out_ready to any output).
REQ-024 Latency: an instruction pushed at edge N SHALL be visible on out_* after edge N (one cycle ROM-to-decode).
REQ-025 On redirect_valid, SHALL flush all entries (buf_count = 0 next cycle), set pc = redirect_pc, enter FETCH from either state, and ignore any same-cycle push and pop.
REQ-026 Simultaneous push and pop SHALL leave buf_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-027 out_* SHALL hold stable while out_valid && !out_ready.
REQ-028 fetch_done SHALL be 1 exactly while in DONE.

Reset
REQ-029 On rst high at a clock edge: pc = 0, state = FETCH, pointers = 0, buf_count = 0.
REQ-030 Reset values: rom_addr = 0, out_valid = 0, fetch_done = 0, buf_count = 0, out_instr = 0, out_pc = 0.
REQ-031 Reset SHALL override redirect, push and pop in the same cycle, including mid-drain and in DONE.

Structure
REQ-032 Shared package SHALL hold ADDR_W, DATA_W defaults, the end-of-trace encoding (32'h0) and the FETCH/DONE state enum.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (sync push/pop/flush, count output); the controller holds pc and FSM.

Verification
REQ-034 ROM words 0..5 = 0x11..0x66, word 6 = 0, out_ready=1 -> out_pc 0..5 with matching instr on consecutive cycles, then fetch_done=1, pc=6.
REQ-035 DEPTH=4, out_ready=0 -> buf_count saturates at 4, pc=4, rom_addr=4; then out_ready=1 -> one pop and one push per cycle, count stays 4.
REQ-036 Redirect to 0x40 while buf_count=3 -> next cycle buf_count=0, out_valid=0; following cycle out_pc=0x40.
REQ-037 Redirect to 0x10 while in DONE -> fetch_done=0 next cycle, fetching resumes at 0x10.
REQ-038 All ROM words nonzero, redirect to 0xFE -> entries 0xFE, 0xFF pushed, then DONE, no wrap to 0.
REQ-039 rst asserted with buf_count=2 and redirect_valid=1 -> all outputs at reset values next cycle, pc=0.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller and its buffer.
// Holds default widths, the end-of-trace word and the FSM state encoding.
package fetch_controller_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // A ROM word of all zeros marks the end of the instruction trace.
    localparam logic [31:0] EOT_WORD = 32'h0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DONE  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular store of {pc, instr} pairs with sync push/pop/flush.
// The head is read straight from the storage registers, never from the inputs.
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        push_pc_i,
    input  logic [DATA_W-1:0]        push_instr_i,
    output logic [ADDR_W-1:0]        head_pc_o,
    output logic [DATA_W-1:0]        head_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
    logic [DATA_W-1:0] mem_instr_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic do_pop;
    logic do_push;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_pc_q[wr_ptr_q]    <= push_pc_i;
                mem_instr_q[wr_ptr_q] <= push_instr_i;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_pc_o    = mem_pc_q[rd_ptr_q];
    assign head_instr_o = mem_instr_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a combinational ROM by word address and
// queues {pc, instr} pairs for decode until end-of-trace or the top address.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | reading ROM at pc, pushing into the buffer when space allows
//   ST_DONE  | trace finished; no pushes, buffer drains until redirect
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic                     fetch_done,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              done_q;

    logic eot;
    logic buf_full;
    logic pop;
    logic push;
    logic pc_last;

    assign eot      = (rom_data == DATA_W'(EOT_WORD));
    assign buf_full = (buf_count == CW'(DEPTH));
    assign pc_last  = &pc_q;

    // A redirect discards everything in flight, so it masks both push and pop.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = (state_q == ST_FETCH) && !redirect_valid && !eot && (!buf_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else if (redirect_valid) begin
            state_q <= ST_FETCH;
            pc_q    <= redirect_pc;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (eot) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (push) begin
                        // The top word is fetched but pc never wraps back to zero.
                        if (pc_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_FETCH;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .push_pc_i    (pc_q),
        .push_instr_i (rom_data),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .count_o      (buf_count)
    );

    assign rom_addr   = pc_q;
    assign out_valid  = (buf_count != '0);
    assign fetch_done = done_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_fetch_controller;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              fetch_done;
    logic [2:0]        buf_count;

    logic [31:0] rom [256];

    int checks   = 0;
    int failures = 0;

    logic [39:0] mq[$];
    int          m_pc;
    bit          m_done;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    fetch_controller #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_done     (fetch_done),
        .buf_count      (buf_count)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, and compare.
    task automatic step(input bit r, input bit ready, input bit redir, input logic [7:0] rpc);
        bit          pop;
        bit          push;
        logic [31:0] w;
        rst            = r;
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (r) begin
            mq.delete();
            m_pc   = 0;
            m_done = 0;
        end else if (redir) begin
            mq.delete();
            m_pc   = int'(rpc);
            m_done = 0;
        end else begin
            w    = rom[m_pc];
            pop  = (mq.size() != 0) && ready;
            push = !m_done && (w != 0) && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (!m_done && w == 0) m_done = 1;
            if (push) begin
                mq.push_back({m_pc[7:0], w});
                if (m_pc == 255) m_done = 1;
                else m_pc++;
            end
        end
        @(posedge clk);
        #1;
        chk("buf_count", 40'(buf_count), 40'(mq.size()));
        chk("out_valid", 40'(out_valid), 40'(mq.size() != 0));
        chk("rom_addr", 40'(rom_addr), 40'(m_pc[7:0]));
        chk("fetch_done", 40'(fetch_done), 40'(m_done));
        if (mq.size() != 0) chk("out_head", {out_pc, out_instr}, mq[0]);
        if (r) chk("rst_head", {out_pc, out_instr}, 40'h0);
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + i;

        // Six instructions then end-of-trace, decode always ready
        for (int i = 0; i < 6; i++) rom[i] = 32'h11 * (i + 1);
        rom[6] = 32'h0;
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
        chk("t034_done", 40'(fetch_done), 40'h1);
        chk("t034_pc", 40'(rom_addr), 40'h6);

        // Redirect out of DONE
        step(0, 1, 1, 8'h10);
        chk("t037_done_clr", 40'(fetch_done), 40'h0);
        step(0, 1, 0, 8'h00);
        chk("t037_resume_pc", 40'(out_pc), 40'h10);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);

        // Backpressure saturates the buffer, then steady push+pop
        rom[6] = 32'hA000_0006;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00);
        chk("t035_full", 40'(buf_count), 40'h4);
        chk("t035_addr", 40'(rom_addr), 40'h4);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            chk("t035_steady", 40'(buf_count), 40'h4);
        end

        // Redirect flushes a partially filled buffer
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
        chk("t036_pre", 40'(buf_count), 40'h3);
        step(0, 0, 1, 8'h40);
        chk("t036_flush", 40'(buf_count), 40'h0);
        chk("t036_invalid", 40'(out_valid), 40'h0);
        step(0, 0, 0, 8'h00);
        chk("t036_pc", 40'(out_pc), 40'h40);

        // Top of address space: fetch 0xFE, 0xFF, then stop without wrapping
        step(0, 0, 1, 8'hFE);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);
        chk("t038_done", 40'(fetch_done), 40'h1);
        chk("t038_nowrap", 40'(rom_addr), 40'hFF);
        chk("t038_count", 40'(buf_count), 40'h2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

        // Reset wins over a same-cycle redirect mid-drain
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h00);
        chk("t039_pre", 40'(buf_count), 40'h2);
        step(1, 1, 1, 8'h33);
        chk("t039_count", 40'(buf_count), 40'h0);
        chk("t039_valid", 40'(out_valid), 40'h0);
        chk("t039_addr", 40'(rom_addr), 40'h0);
        chk("t039_done", 40'(fetch_done), 40'h0);

        // Randomized traffic with sparse end-of-trace words
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if ($urandom_range(0, 23) == 0) rom[i] = 32'h0;
            else if (rom[i] == 32'h0) rom[i] = 32'h1;
        end
        rom[255] = 32'hDEAD_BEEF;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] rpc;
            rpc = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rpc = 8'hF0 | 8'($urandom_range(0, 15));
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
